// File: rtl/sprite_scheduler.sv
// Per-frame sprite command scheduler: walks an entity table on new_frame and streams one command per active entry.
// Optional SPRITE_CULL_EN: entries positioned off the 1280x720 screen are treated as inactive.
module sprite_scheduler #(
    parameter int MAX_SPRITES = 16,
    parameter int NUM_FRAMES  = 5,
    parameter int ANIM_DIV    = 6,
    localparam int IW = $clog2(MAX_SPRITES),
    localparam int FW = $clog2(NUM_FRAMES)
) (
    input  logic          clk_pixel,
    input  logic          sys_rst,
    input  logic          new_frame,
    input  logic          wr_valid,
    input  logic [IW-1:0] wr_index,
    input  logic          wr_active,
    input  logic [10:0]   wr_x,
    input  logic [9:0]    wr_y,
    input  logic [FW-1:0] wr_base_frame,
    output logic          sprite_valid,
    input  logic          sprite_ready,
    output logic [10:0]   sprite_x,
    output logic [9:0]    sprite_y,
    output logic [FW-1:0] sprite_frame_number,
    output logic [IW-1:0] sprite_index,
    output logic          sprite_last,
    output logic          frame_done,
    output logic          busy,
    output logic          overrun
);
    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t          state_reg;
    logic [IW-1:0]   idx_reg;
    logic [CW-1:0]   anim_div_cnt_reg;
    logic [FW-1:0]   anim_phase_reg;
    logic [FW-1:0]   scan_phase_reg;
    logic            valid_reg;
    logic [10:0]     x_out_reg;
    logic [9:0]      y_out_reg;
    logic [FW-1:0]   frame_out_reg;
    logic [IW-1:0]   index_out_reg;
    logic            last_reg;
    logic            frame_done_reg;
    logic            overrun_reg;

    logic            act_reg  [MAX_SPRITES];
    logic [10:0]     x_reg    [MAX_SPRITES];
    logic [9:0]      y_reg    [MAX_SPRITES];
    logic [FW-1:0]   base_reg [MAX_SPRITES];

    logic [MAX_SPRITES-1:0] eligible;
    logic [MAX_SPRITES-1:0] above_idx;
    logic                   has_higher;
    logic [FW:0]            frame_sum;
    logic [FW-1:0]          frame_mod;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SPRITES; gi++) begin : g_entry
            always_ff @(posedge clk_pixel) begin
                if (sys_rst) begin
                    act_reg[gi]  <= 1'b0;
                    x_reg[gi]    <= '0;
                    y_reg[gi]    <= '0;
                    base_reg[gi] <= '0;
                end else if (wr_valid && wr_index == IW'(gi)) begin
                    act_reg[gi]  <= wr_active;
                    x_reg[gi]    <= wr_x;
                    y_reg[gi]    <= wr_y;
                    base_reg[gi] <= wr_base_frame;
                end
            end
`ifdef SPRITE_CULL_EN
            assign eligible[gi] = act_reg[gi] && (x_reg[gi] < 11'd1280) && (y_reg[gi] < 10'd720);
`else
            assign eligible[gi] = act_reg[gi];
`endif
            // Lookahead: any emittable entry strictly above the one being examined
            assign above_idx[gi] = eligible[gi] && (IW'(gi) > idx_reg);
        end
    endgenerate

    assign has_higher = |above_idx;

    always_comb begin
        frame_sum = {1'b0, base_reg[idx_reg]} + {1'b0, scan_phase_reg};
        frame_mod = frame_sum[FW-1:0];
        if (frame_sum >= (FW+1)'(NUM_FRAMES))
            frame_mod = FW'(frame_sum - (FW+1)'(NUM_FRAMES));
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            anim_div_cnt_reg <= '0;
            anim_phase_reg   <= '0;
            scan_phase_reg   <= '0;
            valid_reg        <= 1'b0;
            x_out_reg        <= '0;
            y_out_reg        <= '0;
            frame_out_reg    <= '0;
            index_out_reg    <= '0;
            last_reg         <= 1'b0;
            frame_done_reg   <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (new_frame && state_reg != IDLE)
                overrun_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (new_frame) begin
                        state_reg      <= SCAN;
                        idx_reg        <= '0;
                        // This frame renders with the phase in force before the step
                        scan_phase_reg <= anim_phase_reg;
                        if (anim_div_cnt_reg == CW'(ANIM_DIV - 1)) begin
                            anim_div_cnt_reg <= '0;
                            anim_phase_reg   <= (anim_phase_reg == FW'(NUM_FRAMES - 1)) ?
                                                '0 : anim_phase_reg + FW'(1);
                        end else begin
                            anim_div_cnt_reg <= anim_div_cnt_reg + CW'(1);
                        end
                    end
                end
                SCAN: begin
                    if (eligible[idx_reg]) begin
                        valid_reg     <= 1'b1;
                        x_out_reg     <= x_reg[idx_reg];
                        y_out_reg     <= y_reg[idx_reg];
                        frame_out_reg <= frame_mod;
                        index_out_reg <= idx_reg;
                        last_reg      <= !has_higher;
                        state_reg     <= EMIT;
                    end else if (idx_reg == IW'(MAX_SPRITES - 1)) begin
                        state_reg      <= DONE;
                        frame_done_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                EMIT: begin
                    if (sprite_ready) begin
                        valid_reg <= 1'b0;
                        last_reg  <= 1'b0;
                        if (last_reg) begin
                            state_reg      <= DONE;
                            frame_done_reg <= 1'b1;
                        end else begin
                            idx_reg   <= idx_reg + IW'(1);
                            state_reg <= SCAN;
                        end
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sprite_valid        = valid_reg;
    assign sprite_x            = x_out_reg;
    assign sprite_y            = y_out_reg;
    assign sprite_frame_number = frame_out_reg;
    assign sprite_index        = index_out_reg;
    assign sprite_last         = last_reg;
    assign frame_done          = frame_done_reg;
    assign busy                = (state_reg != IDLE);
    assign overrun             = overrun_reg;
endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed + randomized bench for sprite_scheduler against a table-walk reference model.
// Honours SPRITE_CULL_EN in the model when the design is built with it.
module tb_sprite_scheduler;
    localparam int MAX = 16;
    localparam int NF  = 5;
    localparam int AD  = 6;
    localparam int IW  = 4;
    localparam int FW  = 3;

    logic          clk_pixel = 1'b0;
    logic          sys_rst;
    logic          new_frame;
    logic          wr_valid;
    logic [IW-1:0] wr_index;
    logic          wr_active;
    logic [10:0]   wr_x;
    logic [9:0]    wr_y;
    logic [FW-1:0] wr_base_frame;
    logic          sprite_valid;
    logic          sprite_ready;
    logic [10:0]   sprite_x;
    logic [9:0]    sprite_y;
    logic [FW-1:0] sprite_frame_number;
    logic [IW-1:0] sprite_index;
    logic          sprite_last;
    logic          frame_done;
    logic          busy;
    logic          overrun;

    sprite_scheduler #(.MAX_SPRITES(MAX), .NUM_FRAMES(NF), .ANIM_DIV(AD)) dut (
        .clk_pixel(clk_pixel), .sys_rst(sys_rst), .new_frame(new_frame),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_active(wr_active),
        .wr_x(wr_x), .wr_y(wr_y), .wr_base_frame(wr_base_frame),
        .sprite_valid(sprite_valid), .sprite_ready(sprite_ready),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_frame_number(sprite_frame_number), .sprite_index(sprite_index),
        .sprite_last(sprite_last), .frame_done(frame_done),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int idx;
        int x;
        int y;
        int fr;
        int last;
    } cmd_t;

    int   m_act [MAX];
    int   m_x   [MAX];
    int   m_y   [MAX];
    int   m_base[MAX];
    int   frames_accepted;
    cmd_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_eligible(input int i);
`ifdef SPRITE_CULL_EN
        return m_act[i] != 0 && m_x[i] < 1280 && m_y[i] < 720;
`else
        return m_act[i] != 0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < MAX; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_base[i] = 0;
        end
        frames_accepted = 0;
    endtask

    // Commands a frame must produce: every emittable entry in index order
    task automatic build_expected();
        int phase;
        cmd_t c;
        phase = (frames_accepted / AD) % NF;
        exp_q.delete();
        for (int i = 0; i < MAX; i++) begin
            if (model_eligible(i)) begin
                c.idx = i; c.x = m_x[i]; c.y = m_y[i];
                c.fr = (m_base[i] + phase) % NF; c.last = 0;
                exp_q.push_back(c);
            end
        end
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1;
    endtask

    task automatic write_entry(input int i, input int act, input int x, input int y, input int base);
        @(negedge clk_pixel);
        wr_valid = 1'b1; wr_index = IW'(i); wr_active = (act != 0);
        wr_x = 11'(x); wr_y = 10'(y); wr_base_frame = FW'(base);
        @(negedge clk_pixel);
        wr_valid = 1'b0;
        m_act[i] = act; m_x[i] = x; m_y[i] = y; m_base[i] = base;
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", sprite_valid, 0);
        chk("rst_x", sprite_x, 0);
        chk("rst_y", sprite_y, 0);
        chk("rst_frame", sprite_frame_number, 0);
        chk("rst_index", sprite_index, 0);
        chk("rst_last", sprite_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_pixel);
        sys_rst = 1'b1;
        repeat (2) @(negedge clk_pixel);
        check_reset_outputs();
        sys_rst = 1'b0;
        model_clear();
    endtask

    // mode 0: ready=1; 1: random ready; 2: stall first command 5 cycles;
    // 3: as 2 plus a new_frame pulse during the stall
    task automatic run_frame(input int mode);
        int cyc, done, n_exp, first_idx, cmds_seen, stall;
        logic prev_valid, prev_ready, rdy;
        logic [10:0] h_x; logic [9:0] h_y; logic [FW-1:0] h_fr;
        logic [IW-1:0] h_idx; logic h_last;
        build_expected();
        n_exp = exp_q.size();
        first_idx = (n_exp > 0) ? exp_q[0].idx : -1;
        @(negedge clk_pixel);
        new_frame = 1'b1; sprite_ready = 1'b0;
        @(negedge clk_pixel);
        new_frame = 1'b0;
        frames_accepted++;
        cyc = 0; done = 0; cmds_seen = 0; stall = 0;
        prev_valid = 1'b0; prev_ready = 1'b0;
        h_x = '0; h_y = '0; h_fr = '0; h_idx = '0; h_last = 1'b0;
        while (done == 0 && cyc < 400) begin
            chk("busy_during_scan", busy, 1);
            if (prev_valid && prev_ready) begin
                chk("gap_after_handshake", sprite_valid, 0);
            end else if (prev_valid) begin
                chk("stall_valid", sprite_valid, 1);
                chk("stall_x", sprite_x, h_x);
                chk("stall_y", sprite_y, h_y);
                chk("stall_frame", sprite_frame_number, h_fr);
                chk("stall_index", sprite_index, h_idx);
                chk("stall_last", sprite_last, h_last);
            end
            if (sprite_valid && !prev_valid) begin
                if (cmds_seen == 0) chk("first_latency", cyc, first_idx + 1);
                chk("cmd_available", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    $display("cmd idx=%0d x=%0d y=%0d frame=%0d last=%0d (model idx=%0d frame=%0d last=%0d)",
                             sprite_index, sprite_x, sprite_y, sprite_frame_number, sprite_last,
                             exp_q[0].idx, exp_q[0].fr, exp_q[0].last);
                    chk("cmd_index", sprite_index, exp_q[0].idx);
                    chk("cmd_x", sprite_x, exp_q[0].x);
                    chk("cmd_y", sprite_y, exp_q[0].y);
                    chk("cmd_frame", sprite_frame_number, exp_q[0].fr);
                    chk("cmd_last", sprite_last, exp_q[0].last);
                end
            end
            rdy = 1'b1;
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            if (mode >= 2 && cmds_seen == 0 && sprite_valid) begin
                rdy = (stall >= 5);
                new_frame = (mode == 3 && stall == 2);
                stall++;
            end else begin
                new_frame = 1'b0;
            end
            if (sprite_valid && rdy) begin
                cmds_seen++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (frame_done) begin
                done = 1;
                chk("cmds_emitted", cmds_seen, n_exp);
                chk("valid_at_done", sprite_valid, 0);
                if (n_exp == 0) chk("empty_done_cycle", cyc, MAX);
            end
            h_x = sprite_x; h_y = sprite_y; h_fr = sprite_frame_number;
            h_idx = sprite_index; h_last = sprite_last;
            prev_valid = sprite_valid; prev_ready = rdy;
            sprite_ready = rdy;
            @(negedge clk_pixel);
            cyc++;
        end
        new_frame = 1'b0;
        sprite_ready = 1'b0;
        chk("frame_done_seen", done, 1);
        chk("busy_after_done", busy, 0);
        chk("frame_done_one_cycle", frame_done, 0);
        $display("frame %0d mode=%0d commands=%0d cycles=%0d", frames_accepted - 1, mode, cmds_seen, cyc);
    endtask

    initial begin
        sys_rst = 1'b1; new_frame = 1'b0; wr_valid = 1'b0; wr_index = '0;
        wr_active = 1'b0; wr_x = '0; wr_y = '0; wr_base_frame = '0; sprite_ready = 1'b0;
        model_clear();
        do_reset();

        // Empty table: full walk, no commands
        run_frame(0);

        // Two active entries, free-flowing renderer
        write_entry(2, 1, 100, 200, 1);
        write_entry(9, 1, $urandom_range(0, 1279), $urandom_range(0, 719), 3);
        run_frame(0);

        // Backpressure on first command
        run_frame(2);

        // new_frame during a stalled command is ignored but flagged
        chk("overrun_before", overrun, 0);
        run_frame(3);
        chk("overrun_sticky", overrun, 1);
        run_frame(0);
        chk("overrun_still_set", overrun, 1);

        // Reset in the middle of a scan
        @(negedge clk_pixel);
        new_frame = 1'b1;
        @(negedge clk_pixel);
        new_frame = 1'b0;
        repeat (3) @(negedge clk_pixel);
        chk("valid_before_midscan_reset", sprite_valid, 1);
        sys_rst = 1'b1;
        @(negedge clk_pixel);
        chk("midscan_rst_valid", sprite_valid, 0);
        chk("midscan_rst_busy", busy, 0);
        chk("midscan_rst_overrun", overrun, 0);
        sys_rst = 1'b0;
        model_clear();
        run_frame(0);

        // Animation: base 4 across 12 frames
        write_entry(5, 1, 640, 360, 4);
        for (int f = 0; f < 12; f++) run_frame(0);

        // Randomized table contents and backpressure
        for (int it = 0; it < 20; it++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++)
                write_entry($urandom_range(0, MAX - 1), $urandom_range(0, 1),
                            $urandom_range(0, 2047), $urandom_range(0, 1023),
                            $urandom_range(0, NF - 1));
            run_frame(1);
        end

        // Off-screen entry above the last on-screen one
        do_reset();
        write_entry(4, 1, 1279, 719, 2);
        write_entry(12, 1, 1300, 100, 0);
        run_frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sprite_scheduler.md
Name: sprite_scheduler

Overview:
- Holds a table of up to MAX_SPRITES game entities (active flag, position, base animation frame) written by game logic.
- Once per video frame, on the new-frame pulse, walks the table and emits one sprite command per active entry over a valid/ready stream to the sprite renderer in `graphics`.
- Keeps a global animation phase, so each entity's emitted frame number advances every ANIM_DIV video frames.
- Sits between game-state logic and the graphics pipeline; the renderer no longer needs to be tied to constant sprite inputs.

Parameters:
- MAX_SPRITES, 16, number of table entries; index width IW = $clog2(MAX_SPRITES).
- NUM_FRAMES, 5, animation frames per sprite sheet; frame width FW = $clog2(NUM_FRAMES).
- ANIM_DIV, 6, video frames per animation step (must be ≥1).

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- new_frame  in  1  one-cycle pulse at the start of each video frame.
- wr_valid  in  1  table write strobe.
- wr_index  in  IW  entry written.
- wr_active  in  1  entry active flag.
- wr_x  in  11  entity x position.
- wr_y  in  10  entity y position.
- wr_base_frame  in  FW  base animation frame (< NUM_FRAMES).
- sprite_valid  out  1  command valid.
- sprite_ready  in  1  renderer accepts command.
- sprite_x  out  11  command x.
- sprite_y  out  10  command y.
- sprite_frame_number  out  FW  command frame.
- sprite_index  out  IW  table index of command.
- sprite_last  out  1  final command of this frame's scan.
- frame_done  out  1  one-cycle pulse when a scan completes.
- busy  out  1  high while not IDLE.
- overrun  out  1  sticky; set when new_frame arrives while busy.

Behaviour:
- Reset values:
  - Every output is 0.
  - All table entries are inactive with x/y/base 0.
  - anim_phase = 0, anim_div_cnt = 0, state = IDLE.
- Table write:
  - When wr_valid is high, the entry is updated at the next clock edge, in any state.
  - A write to an index the scan has already passed takes effect next frame.
  - A write to the entry currently being examined takes effect this frame only if it lands before that entry is loaded into the output register.
- Animation:
  - Each new_frame accepted in IDLE increments anim_div_cnt.
  - When anim_div_cnt reaches ANIM_DIV-1, it resets to 0 and anim_phase advances by 1, wrapping NUM_FRAMES-1 → 0.
  - Frame number = (base + anim_phase) mod NUM_FRAMES, computed in FW+1 bits with a single conditional subtract.
- FSM states: IDLE, SCAN, EMIT, DONE.
  - IDLE: on new_frame → SCAN with idx = 0. Any other cycle stays in IDLE.
  - SCAN: examines entry idx in one cycle.
    - Inactive entry: idx+1.
    - Active entry: load the output register, assert sprite_valid → EMIT.
    - After idx = MAX_SPRITES-1 has been examined with no pending emit → DONE.
  - EMIT: holds all sprite_* outputs stable while sprite_valid && !sprite_ready. On the handshake:
    - If sprite_last is set → DONE.
    - Otherwise deassert sprite_valid, idx+1 → SCAN.
  - DONE: frame_done = 1 for one cycle → IDLE.
- sprite_last: set when the loaded entry has no active entry at a higher index, determined by a lookahead OR over the active flags above idx.
- Empty table: the scan walks all MAX_SPRITES entries, emits nothing, then pulses frame_done. Scan duration is MAX_SPRITES+1 cycles.
- Latency:
  - new_frame to first sprite_valid = k+1 cycles, where k is the index of the first active entry.
  - Between consecutive commands, there is a minimum of 1 idle cycle after the handshake.
- new_frame while busy:
  - The pulse is ignored: no restart, no anim step.
  - overrun is set and stays set until sys_rst.
- sys_rst mid-scan: returns to IDLE next cycle, drops sprite_valid immediately, and clears the table.

Optional Feature:
- Macro: SPRITE_CULL_EN.
- Defined: active entries with x ≥ 1280 or y ≥ 720 are treated as inactive, both for emission and for the sprite_last lookahead.
- Not defined: every active entry is emitted regardless of position.

Test Plan:
- Reset, empty table, new_frame → no sprite_valid; frame_done 17 cycles later; busy high for 17 cycles.
- Entries 2 (x=100, y=200, base=1) and 9 active, sprite_ready tied 1 → two commands (index 2 then 9); only index 9 has sprite_last = 1; frame_done follows.
- Hold sprite_ready = 0 for 5 cycles during a command → outputs stable across all 5 cycles; released exactly once.
- ANIM_DIV = 6, base = 4, run 12 frames → frame_number is 4 for frames 0–5 and 0 for frames 6–11.
- new_frame pulsed while sprite_ready is held low → overrun = 1, anim_phase unchanged, current scan completes normally.
- SPRITE_CULL_EN defined, entry at x = 1300 active → not emitted; the preceding active entry carries sprite_last.
